// File: rtl/mac_array.sv
// N-lane signed multiply-accumulate array: one beat per cycle, N beats per frame,
// all lane sums presented on C with a one-cycle valid strobe two cycles after the last beat.
module mac_array #(
  parameter int N       = 6,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2*WIDTH+N-1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sof,
  input  logic [N*WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]     B,
  output logic [N*M_WIDTH-1:0] C,
  output logic [N-1:0]         valid,
  output logic                 busy,
  output logic                 err
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int P_W   = 2*WIDTH;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic                       take, first, last, abort;

  logic signed [P_W-1:0]      prod_p1 [N];
  logic                       vld_p1, first_p1, last_p1;
  logic signed [M_WIDTH-1:0]  acc_p2 [N];
  logic                       done_p2;

  function automatic logic signed [P_W-1:0] mul(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
    logic signed [P_W-1:0] ea, eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

  function automatic logic signed [M_WIDTH-1:0] sext(input logic signed [P_W-1:0] p);
    logic signed [M_WIDTH-1:0] r;
    r = p;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= abort;
    end
  end

  // An early sof in ACCUM restarts the frame; the first flag makes stage 2 drop the partial sum.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (sof) begin
          take  = 1'b1;
          first = 1'b1;
          if (N == 1) begin
            last = 1'b1;
          end else begin
            state_nxt = ACCUM;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ACCUM: begin
        take = 1'b1;
        if (sof) begin
          abort   = 1'b1;
          first   = 1'b1;
          cnt_nxt = CNT_W'(1);
        end else if (cnt == CNT_W'(N-1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ACCUM);

  // Stage 1: per-lane products and beat flags
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      prod_p1[i] <= mul($signed(A[i*WIDTH +: WIDTH]), $signed(B));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= take;
      first_p1 <= first;
      last_p1  <= last;
    end
  end

  // Stage 2: accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) acc_p2[i] <= '0;
      done_p2 <= 1'b0;
    end else begin
      done_p2 <= vld_p1 & last_p1;
      if (vld_p1) begin
        for (int i = 0; i < N; i++)
          acc_p2[i] <= first_p1 ? sext(prod_p1[i]) : acc_p2[i] + sext(prod_p1[i]);
      end
    end
  end

  // Stage 3: publish results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C     <= '0;
      valid <= '0;
    end else begin
      valid <= {N{done_p2}};
      if (done_p2) begin
        for (int i = 0; i < N; i++)
          C[i*M_WIDTH +: M_WIDTH] <= acc_p2[i];
      end
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// Directed testbench for mac_array: default N=6 instance plus an N=1 instance.
module tb_mac_array;
  localparam int N  = 6;
  localparam int W  = 16;
  localparam int M  = 2*W+N-1;
  localparam int M1 = 2*W;

  logic              clk = 1'b0;
  logic              rst;
  logic              sof;
  logic [N*W-1:0]    A;
  logic [W-1:0]      B;
  logic [N*M-1:0]    C;
  logic [N-1:0]      valid;
  logic              busy, err;

  logic              sof1;
  logic [W-1:0]      A1, B1;
  logic signed [M1-1:0] C1;
  logic [0:0]        valid1;
  logic              busy1, err1;

  int n_tests = 0;
  int n_fail  = 0;

  mac_array #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sof(sof), .A(A), .B(B),
    .C(C), .valid(valid), .busy(busy), .err(err)
  );

  mac_array #(.N(1), .WIDTH(W)) dut1 (
    .clk(clk), .rst(rst), .sof(sof1), .A(A1), .B(B1),
    .C(C1), .valid(valid1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] lane(input int i);
    logic signed [M-1:0] t;
    t = C[i*M +: M];
    return t;
  endfunction

  function automatic logic [N*W-1:0] a_const(input int v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [N*W-1:0] a_ramp();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(i+1);
    return r;
  endfunction

  task automatic step(input logic s, input logic [N*W-1:0] a, input int b);
    sof = s;
    A   = a;
    B   = W'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [N*W-1:0] a, input int b0, input int binc,
                           input logic chk_busy);
    for (int k = 0; k < N; k++) begin
      step(k == 0, a, b0 + k*binc);
      if (chk_busy) chk("busy", busy, (k < N-1) ? 1 : 0);
    end
  endtask

  task automatic check_out(input string tag, input longint base, input logic ramp);
    step(1'b0, '0, 0);
    chk({tag, "_valid_early"}, valid, 0);
    step(1'b0, '0, 0);
    chk({tag, "_valid"}, valid, 63);
    for (int i = 0; i < N; i++)
      chk({tag, "_lane"}, lane(i), ramp ? base*(i+1) : base);
    step(1'b0, '0, 0);
    chk({tag, "_valid_late"}, valid, 0);
  endtask

  initial begin
    rst = 1'b1; sof = 1'b0; A = '0; B = '0;
    sof1 = 1'b0; A1 = '0; B1 = '0;
    #1;
    chk("rst_C", lane(0), 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_C1", C1, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Defaults: lanes 1..6, B = 1..6
    run_frame(a_ramp(), 1, 1, 1'b1);
    chk("dflt_err", err, 0);
    check_out("dflt", 21, 1'b1);

    // Signed extremes
    run_frame(a_const(-32768), -32768, 0, 1'b0);
    check_out("ext_min", 64'sd6442450944, 1'b0);
    run_frame(a_const(-1), 32767, 0, 1'b0);
    check_out("ext_neg", -196602, 1'b0);

    // Back-to-back frames
    for (int k = 0; k < 14; k++) begin
      step(k == 0 || k == 6, (k < 6) ? a_const(1) : (k < 12) ? a_const(2) : '0,
           (k < 6) ? 1 : (k < 12) ? 3 : 0);
      chk("b2b_valid", valid, (k == 7 || k == 13) ? 63 : 0);
      if (k == 7)  for (int i = 0; i < N; i++) chk("b2b_f1", lane(i), 6);
      if (k == 13) for (int i = 0; i < N; i++) chk("b2b_f2", lane(i), 36);
    end

    // Early sof at beat 3
    for (int k = 0; k < 12; k++) begin
      step(k == 0 || k == 3, (k < 9) ? a_const(1) : '0, (k < 9) ? 1 : 0);
      chk("esof_err", err, (k == 3) ? 1 : 0);
      chk("esof_valid", valid, (k == 10) ? 63 : 0);
      if (k == 10) for (int i = 0; i < N; i++) chk("esof_lane", lane(i), 6);
    end

    // Reset mid-frame, asserted between edges during beat 2
    step(1'b1, a_const(1), 1);
    step(1'b0, a_const(1), 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_C0", lane(0), 0);
    chk("mrst_C5", lane(5), 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_busy", busy, 0);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, a_const(1), 1);
      chk("mrst_novalid", valid, 0);
      chk("mrst_idle", busy, 0);
    end
    run_frame(a_const(1), 2, 0, 1'b0);
    check_out("mrst_frame", 12, 1'b0);

    // N=1 instance
    for (int k = 0; k < 4; k++) begin
      sof1 = (k == 0);
      A1   = (k == 0) ? W'(7) : '0;
      B1   = (k == 0) ? W'(-3) : '0;
      step(1'b0, '0, 0);
      chk("n1_busy", busy1, 0);
      chk("n1_valid", valid1, (k == 2) ? 1 : 0);
      if (k == 2) chk("n1_C", C1, -21);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
